d_debounce: RTL and testbench

Single-bit input conditioner that sits directly downstream of the D flip-flop stage and consumes its `q` output, or any slow, possibly asynchronous level. It synchronises the level into `clk`, accepts a new value only after it has been stable for `STABLE` consecutive samples, and emits the filtered level. It also produces one-cycle rise/fall pulses and a saturating count of accepted transitions.

---
 rtl/d_debounce_if.sv | 22 ++
 rtl/d_debounce.sv | 140 ++++++++++++++
 tb/tb_d_debounce.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/d_debounce_if.sv
// d_debounce_if: groups the level input, the edge-count clear and all
// conditioned outputs of the debouncer. The consumer of the filtered level
// uses the master modport; the debouncer itself uses the slave modport.
interface d_debounce_if;
  logic       d_in;
  logic       clr;
  logic       q;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] edge_cnt;

  modport master (
    output d_in, clr,
    input  q, rise, fall, busy, edge_cnt
  );

  modport slave (
    input  d_in, clr,
    output q, rise, fall, busy, edge_cnt
  );
endinterface

// File: rtl/d_debounce.sv
// d_debounce: single-bit level conditioner.
// The raw level is registered into clk. A new value is accepted only after it
// has been seen for STABLE consecutive samples. The block also emits one-cycle
// rise/fall pulses and keeps a saturating count of accepted transitions.
//
// Configuration macro DEBOUNCE_SYNC_EN:
//   defined   - two-flop synchroniser ahead of the qualifier (asynchronous d_in),
//               accept latency STABLE+2 edges.
//   undefined - single input register (d_in already in the clk domain),
//               accept latency STABLE+1 edges.
module d_debounce #(
  parameter int STABLE = 4,
  parameter int CNT_W  = 8
) (
  input logic        clk,
  input logic        rst,
  d_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [7:0]       SAT  = 8'hFF;

  // The qualifier state is implicit in the stability counter: zero means the
  // output agrees with the input, non-zero means a candidate is being timed.
  typedef enum logic {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  logic             sample;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             q_r;
  logic             q_nxt;
  logic             rise_r;
  logic             rise_nxt;
  logic             fall_r;
  logic             fall_nxt;
  logic [7:0]       edge_r;
  logic [7:0]       edge_nxt;
  logic             accept;
  state_t           state;

`ifdef DEBOUNCE_SYNC_EN
  logic meta;

  // Two-flop synchroniser; only its second stage feeds the qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sample <= 1'b0;
    end else begin
      meta   <= bus.d_in;
      sample <= meta;
    end
  end
`else
  // Single input register for a level already timed by clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= 1'b0;
    end else begin
      sample <= bus.d_in;
    end
  end
`endif

  assign state = (cnt == '0) ? IDLE : QUALIFY;

  // Next-state logic: time a differing sample, drop it on any agreement,
  // and commit it once it has been seen STABLE times in a row.
  always_comb begin
    cnt_nxt  = cnt;
    q_nxt    = q_r;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    edge_nxt = edge_r;
    accept   = 1'b0;

    unique case (state)
      IDLE: begin
        if (sample != q_r) begin
          if (cnt == LAST) begin
            accept = 1'b1;
          end else begin
            cnt_nxt = ONE;
          end
        end
      end
      QUALIFY: begin
        if (sample == q_r) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          accept = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: cnt_nxt = '0;
    endcase

    if (accept) begin
      q_nxt    = sample;
      cnt_nxt  = '0;
      rise_nxt = sample;
      fall_nxt = ~sample;
    end

    if (bus.clr) begin
      edge_nxt = 8'd0;
    end else if (accept && (edge_r != SAT)) begin
      edge_nxt = edge_r + 8'd1;
    end
  end

  // State and output registers; reset abandons any qualification in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      q_r    <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      edge_r <= 8'd0;
    end else begin
      cnt    <= cnt_nxt;
      q_r    <= q_nxt;
      rise_r <= rise_nxt;
      fall_r <= fall_nxt;
      edge_r <= edge_nxt;
    end
  end

  assign bus.q        = q_r;
  assign bus.rise     = rise_r;
  assign bus.fall     = fall_r;
  assign bus.busy     = (cnt != '0);
  assign bus.edge_cnt = edge_r;

endmodule

// File: tb/tb_d_debounce.sv
// tb_d_debounce: scoreboard bench for d_debounce. Every driven cycle pushes
// the outputs expected after the next rising edge into a queue; a monitor pops
// and compares them shortly after that edge. Directed scenarios add checks
// with expectations worked out from the accept latency.
module tb_d_debounce;

  localparam int STABLE = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = STABLE + 2;
`else
  localparam int LAT = STABLE + 1;
`endif

  typedef struct {
    logic       q;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] edge_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exp_t sb_queue[$];
  int   assertions = 0;
  int   failures   = 0;

  logic m_meta = 1'b0;
  logic m_smp  = 1'b0;
  logic m_q    = 1'b0;
  int   m_run  = 0;
  int   m_ec   = 0;

  int   rise_seen;
  int   fall_seen;
  int   busy_seen;
  int   rise_at;
  int   fall_at;
  logic d_lvl;

  d_debounce_if bus_if ();

  d_debounce #(
    .STABLE(STABLE),
    .CNT_W (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // 20 ns clock
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertions++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: counts how long the sampled level has disagreed with the
  // filtered level and accepts it once the run reaches STABLE.
  task automatic modelStep(input logic d, input logic c, input logic r, output exp_t e);
    logic cur;
    logic acc;
    cur = 1'b0;
    acc = 1'b0;
    if (r) begin
      m_meta = 1'b0;
      m_smp  = 1'b0;
      m_q    = 1'b0;
      m_run  = 0;
      m_ec   = 0;
    end else begin
      cur = m_smp;
`ifdef DEBOUNCE_SYNC_EN
      m_smp  = m_meta;
      m_meta = d;
`else
      m_smp  = d;
`endif
      if (cur != m_q) begin
        m_run++;
        if (m_run >= STABLE) begin
          acc   = 1'b1;
          m_q   = cur;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (c) m_ec = 0;
      else if (acc && m_ec < 255) m_ec++;
    end
    e.q        = m_q;
    e.rise     = acc & cur;
    e.fall     = acc & ~cur;
    e.busy     = (m_run != 0);
    e.edge_cnt = m_ec[7:0];
  endtask

  task automatic applyStimulus(input logic d, input logic c, input logic r);
    exp_t e;
    @(negedge clk);
    bus_if.d_in = d;
    bus_if.clr  = c;
    rst         = r;
    modelStep(d, c, r, e);
    sb_queue.push_back(e);
    @(posedge clk);
    #2;
    if (bus_if.rise) rise_seen++;
    if (bus_if.fall) fall_seen++;
    if (bus_if.busy) busy_seen++;
  endtask

  // Scoreboard monitor: compare the DUT against the entry queued for this edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb_queue.size() != 0) begin
      e = sb_queue.pop_front();
      checkOutput("sb_q",        bus_if.q,        e.q);
      checkOutput("sb_rise",     bus_if.rise,     e.rise);
      checkOutput("sb_fall",     bus_if.fall,     e.fall);
      checkOutput("sb_busy",     bus_if.busy,     e.busy);
      checkOutput("sb_edge_cnt", bus_if.edge_cnt, e.edge_cnt);
      checkOutput("sb_onehot",   bus_if.rise & bus_if.fall, 0);
    end
  end

  initial begin
    int n;
    int hold;
    rst         = 1'b1;
    bus_if.d_in = 1'b0;
    bus_if.clr  = 1'b0;
    rise_seen   = 0;
    fall_seen   = 0;
    busy_seen   = 0;

    // Reset with the level held high, then release: one rise after LAT edges.
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("reset_q",        bus_if.q,        0);
    checkOutput("reset_busy",     bus_if.busy,     0);
    checkOutput("reset_edge_cnt", bus_if.edge_cnt, 0);
    for (int i = 1; i <= LAT + 1; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("release_q",    bus_if.q,    (i >= LAT) ? 1 : 0);
      checkOutput("release_rise", bus_if.rise, (i == LAT) ? 1 : 0);
    end
    checkOutput("release_edge_cnt", bus_if.edge_cnt, 1);

    // Return to 0, then a 3-cycle glitch that must be discarded.
    repeat (LAT + 4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pre_glitch_edge_cnt", bus_if.edge_cnt, 2);
    rise_seen = 0; fall_seen = 0; busy_seen = 0;
    repeat (STABLE - 1) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (LAT + 6)    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("glitch_busy_cycles", busy_seen,       STABLE - 1);
    checkOutput("glitch_rise",        rise_seen,       0);
    checkOutput("glitch_q",           bus_if.q,        0);
    checkOutput("glitch_edge_cnt",    bus_if.edge_cnt, 2);

    // A pulse of exactly STABLE cycles is accepted, and so is its trailing edge.
    rise_seen = 0; fall_seen = 0;
    rise_at = 0; fall_at = 0; n = 0;
    for (int i = 0; i < STABLE + LAT + 8; i++) begin
      n++;
      applyStimulus((i < STABLE) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      if (bus_if.rise) rise_at = n;
      if (bus_if.fall) fall_at = n;
    end
    checkOutput("exact_rise_edge", rise_at,         LAT);
    checkOutput("exact_fall_edge", fall_at,         LAT + STABLE);
    checkOutput("exact_rises",     rise_seen,       1);
    checkOutput("exact_falls",     fall_seen,       1);
    checkOutput("exact_edge_cnt",  bus_if.edge_cnt, 4);

    // Pseudo-random hold times with occasional clears, checked by the scoreboard.
    d_lvl = 1'b0;
    n = 0;
    while (n < 1000) begin
      hold  = $urandom_range(0, 7);
      d_lvl = ~d_lvl;
      for (int k = 0; k < hold; k++) begin
        applyStimulus(d_lvl, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, 1'b0);
      end
      n += hold;
    end

    // Saturation: 300 toggles, each held long enough to be accepted.
    for (int t = 0; t < 300; t++) begin
      d_lvl = ~d_lvl;
      repeat (STABLE + 2) applyStimulus(d_lvl, 1'b0, 1'b0);
    end
    repeat (LAT + 2) applyStimulus(d_lvl, 1'b0, 1'b0);
    checkOutput("sat_edge_cnt", bus_if.edge_cnt, 255);
    repeat (10) applyStimulus(d_lvl, 1'b0, 1'b0);
    checkOutput("sat_hold", bus_if.edge_cnt, 255);

    // Clear landing on the accepting edge: count zeroed, pulse still emitted.
    d_lvl = ~d_lvl;
    for (int k = 1; k <= LAT; k++) begin
      applyStimulus(d_lvl, (k == LAT) ? 1'b1 : 1'b0, 1'b0);
    end
    checkOutput("clr_edge_cnt", bus_if.edge_cnt, 0);
    checkOutput("clr_pulse",    bus_if.rise | bus_if.fall, 1);
    checkOutput("clr_q",        bus_if.q, d_lvl);

    // Reset while the counter sits at 2: aborted, no pulse, then one rise.
    repeat (LAT + 2) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (LAT - 2) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_busy", bus_if.busy, 1);
    rise_seen = 0; fall_seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("midrst_q",        bus_if.q,        0);
    checkOutput("midrst_rise",     bus_if.rise,     0);
    checkOutput("midrst_fall",     bus_if.fall,     0);
    checkOutput("midrst_busy",     bus_if.busy,     0);
    checkOutput("midrst_edge_cnt", bus_if.edge_cnt, 0);
    rise_at = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (bus_if.rise) rise_at = i;
    end
    checkOutput("postrst_rise_edge", rise_at,         LAT);
    checkOutput("postrst_rises",     rise_seen,       1);
    checkOutput("postrst_edge_cnt",  bus_if.edge_cnt, 1);

    @(posedge clk);
    #5;
    checkOutput("sb_drained", sb_queue.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
